piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a
//   valid/ready load handshake and shifts it out one bit per clock with framing
//   strobes. It is the sending end of the serial link fed by the parallel
//   register datapath; the matching SIPO receiver sits at the other end.
// PARAMETERS
//   WIDTH      4   bits per frame; must be >= 2
//   MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//   clk          in   1      rising-edge clock
//   clr          in   1      reset: asynchronous, active-high; clears all state
//   din          in   WIDTH  parallel word to send
//   load_valid   in   1      producer has a word on din
//   load_ready   out  1      block accepts din on this edge if load_valid=1
//   sout         out  1      serial data bit
//   sout_valid   out  1      sout carries a frame bit this cycle
//   frame_start  out  1      high during the first bit of each frame
//   done         out  1      one-cycle pulse after a frame's last bit edge
// BEHAVIOUR
//   State: shreg[WIDTH-1:0], cnt[$clog2(WIDTH)-1:0], FSM {IDLE, SHIFT}.
//   Reset (clr=1, async, any time): state=IDLE, shreg=0, cnt=0, done=0.
//     Outputs while in reset: load_ready=1, sout=0, sout_valid=0,
//     frame_start=0, done=0. A frame in progress is discarded; the first word
//     after release is a fresh frame.
//   Outputs are decoded from registered state only. They have no
//     combinational path from din or load_valid.
//     sout_valid  = (state==SHIFT)
//     sout        = sout_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 0
//     frame_start = (state==SHIFT && cnt==0)
//     load_ready  = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1)
//   Accept: an edge with load_valid && load_ready does all of the following:
//     shreg<=din, cnt<=0, state<=SHIFT.
//     Latency: the first bit appears on sout in the cycle right after the
//     accepting edge.
//   SHIFT, cnt<WIDTH-1: each edge shifts shreg by one toward the output end
//     (left if MSB_FIRST, else right), zero-fill, and sets cnt<=cnt+1.
//     load_valid is ignored. The producer holds din and load_valid.
//   SHIFT, cnt==WIDTH-1 (last bit):
//     - The edge sets done<=1 for exactly one cycle.
//     - If load_valid=1: accept the new word. This gives back-to-back frames
//       with no idle cycle; sout_valid stays 1 and frame_start rises for the
//       new frame.
//     - Else: state<=IDLE, cnt<=0.
//   done is 0 on every other edge.
//   A frame is exactly WIDTH consecutive sout_valid cycles.
//   cnt never exceeds WIDTH-1. cnt wraps only by reloading to 0.
//   IDLE with load_valid=0: nothing changes; sout held at 0.
// TESTING
//   1 Assert clr for 10ns, with din=1010 and load_valid=1 during reset
//     -> all outputs stay at reset values and load_ready=1; no frame starts.
//   2 WIDTH=4, MSB_FIRST=1: load 1010 in a single cycle
//     -> sout=1,0,1,0 on the 4 following cycles; sout_valid high exactly 4
//        cycles; frame_start high on the first only; done pulses on the cycle
//        after the 4th bit; then idle.
//   3 MSB_FIRST=0: load 1001 then 0011
//     -> sout=1,0,0,1 then 1,1,0,0.
//   4 Back-to-back: load 1010, then hold load_valid=1 with din=1111
//     -> 8 consecutive valid bits 1,0,1,0,1,1,1,1; frame_start on bits 1 and 5;
//        load_ready high only in IDLE and in the last-bit cycle.
//   5 Load 1111 and change din to 0000 with load_valid=1 during bits 2-3
//     -> output is still 1,1,1,1; 0000 is accepted only in the last-bit cycle,
//        then sent as 0,0,0,0.
//   6 Load 1111 and pulse clr asynchronously between edges after bit 2
//     -> sout and sout_valid drop immediately with no done pulse; after
//        release, loading 1001 gives a clean 1,0,0,1 with frame_start.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load/serial bundle for piso_serializer.
//   master: producer/observer side -- drives din, load_valid; sees the rest.
//   slave : serializer side -- takes din, load_valid; drives load_ready,
//           sout, sout_valid, frame_start, done.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             done;

  modport master (
    output din, load_valid,
    input  load_ready, sout, sout_valid, frame_start, done
  );

  modport slave (
    input  din, load_valid,
    output load_ready, sout, sout_valid, frame_start, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter.
// A WIDTH-bit word is taken over a valid/ready load handshake and sent one bit
// per clock, MSB or LSB first, with framing strobes.
//   clk  : rising-edge clock
//   clr  : asynchronous active-high clear, drops any frame in progress
//   bus  : slave side of piso_serializer_if
//          din/load_valid in, load_ready/sout/sout_valid/frame_start/done out
// All outputs decode registered state only; din/load_valid only steer the
// next-state logic.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 clr,
  piso_serializer_if.slave     bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             done_q,  done_d;

  logic last_bit, load_ready, accept;

  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
  // Accepting during the last bit gives gap-free back-to-back frames.
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = bus.load_valid && load_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (!last_bit) begin
          // Move the next bit toward the output end, zero-fill behind it.
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1);
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A load overrides the idle/last-bit fallthrough above.
    if (accept) begin
      shreg_d = bus.din;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.sout_valid  = (state_q == SHIFT);
  assign bus.sout        = (state_q == SHIFT) &
                           (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign bus.frame_start = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.done        = done_q;
endmodule
